// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family: group width,
// group propagate/generate record and a group-count helper.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } group_pg_t;

    function automatic int n_groups(input int width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice: sum bits from the incoming carry, plus the
// group propagate/generate pair used by the lookahead one level up.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output group_pg_t          pg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c;
    assign pg.p = &p;
    assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/sub: each stage resolves N 4-bit groups and
// hands the remaining operand slices plus the carry to the next stage.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int GROUPS   = n_groups(WIDTH);
    localparam int STAGES_S = (STAGES < 1) ? 1 : STAGES;
    localparam int N        = (GROUPS / STAGES_S < 1) ? 1 : GROUPS / STAGES_S;
    localparam int STAGE_W  = N * GROUP_W;

    generate
        if ((WIDTH % GROUP_W != 0) || (WIDTH < GROUP_W) || (STAGES < 1) ||
            (STAGES > GROUPS) || (GROUPS % STAGES_S != 0)) begin : g_bad_params
            $error("pipelined_cla_addsub: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
        end
    endgenerate

    logic [STAGES-1:0] v_all;
    logic [STAGES:0]   adv;

    assign adv[STAGES] = out_ready;
    assign in_ready    = adv[0];

    genvar gi, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO_IN  = gi * STAGE_W;
            localparam int LO_OUT = LO_IN + STAGE_W;
            localparam int REM    = WIDTH - LO_IN;

            logic [REM-1:0]     a_cur;
            logic [REM-1:0]     b_cur;
            logic               c_cur;
            logic               v_cur;
            logic [STAGE_W-1:0] s_cur;
            logic [LO_OUT-1:0]  sum_next;
            group_pg_t          pg [N];
            logic [N:0]         gc;

            logic               v_reg;
            logic [LO_OUT-1:0]  sum_reg;
            logic               c_reg;

            if (gi == 0) begin : g_src
                assign a_cur    = a;
                assign b_cur    = b ^ {WIDTH{sub}};
                assign c_cur    = c_in ^ sub;
                assign v_cur    = in_valid;
                assign sum_next = s_cur;
            end else begin : g_src
                assign a_cur    = g_stage[gi-1].g_fwd.a_reg;
                assign b_cur    = g_stage[gi-1].g_fwd.b_reg;
                assign c_cur    = g_stage[gi-1].c_reg;
                assign v_cur    = v_all[gi-1];
                assign sum_next = {s_cur, g_stage[gi-1].sum_reg};
            end

            for (gj = 0; gj < N; gj++) begin : g_grp
                cla_group4 u_grp (
                    .a   (a_cur[gj*GROUP_W +: GROUP_W]),
                    .b   (b_cur[gj*GROUP_W +: GROUP_W]),
                    .cin (gc[gj]),
                    .sum (s_cur[gj*GROUP_W +: GROUP_W]),
                    .pg  (pg[gj])
                );
            end

            // Flat lookahead: each group carry-in is a sum of products over
            // lower group generates and the stage carry, not a ripple chain.
            always_comb begin
                gc    = '0;
                gc[0] = c_cur;
                for (int j = 0; j < N; j++) begin
                    logic run_p;
                    run_p     = 1'b1;
                    gc[j + 1] = 1'b0;
                    for (int i = j; i >= 0; i--) begin
                        gc[j + 1] = gc[j + 1] | (pg[i].g & run_p);
                        run_p     = run_p & pg[i].p;
                    end
                    gc[j + 1] = gc[j + 1] | (run_p & c_cur);
                end
            end

            // Stage advances when empty or when its successor advances.
            assign v_all[gi] = v_reg;
            assign adv[gi]   = out_ready || !(&v_all[STAGES-1:gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_reg   <= 1'b0;
                    sum_reg <= '0;
                    c_reg   <= 1'b0;
                end else if (adv[gi]) begin
                    v_reg <= v_cur;
                    if (v_cur) begin
                        sum_reg <= sum_next;
                        c_reg   <= gc[N];
                    end
                end
            end

            if (gi < STAGES - 1) begin : g_fwd
                logic [WIDTH-LO_OUT-1:0] a_reg;
                logic [WIDTH-LO_OUT-1:0] b_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (adv[gi] && v_cur) begin
                        a_reg <= a_cur[REM-1:STAGE_W];
                        b_reg <= b_cur[REM-1:STAGE_W];
                    end
                end
            end else begin : g_out
                logic msb_c_next;
                logic msb_c_reg;

                // Carry into the MSB recovered from its sum bit and operands.
                assign msb_c_next = s_cur[STAGE_W-1] ^ a_cur[REM-1] ^ b_cur[REM-1];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        msb_c_reg <= 1'b0;
                    end else if (adv[gi] && v_cur) begin
                        msb_c_reg <= msb_c_next;
                    end
                end

                assign out_valid = v_reg;
                assign sum       = sum_reg;
                assign c_out     = c_reg;
                assign overflow  = msb_c_reg ^ c_reg;
                assign zero      = v_reg && (sum_reg == '0);
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: directed corner vectors,
// backpressure, mid-operation reset and a random handshake run.
module tb_pipelined_cla_addsub;

    localparam int W = 32;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         zero;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   out_fires = 0;
    exp_t sb [$];
    exp_t popped;
    exp_t held;
    logic stall_prev = 1'b0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sv, input logic cv);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        logic [W-1:0] low;
        be     = sv ? ~bv : bv;
        ce     = cv ^ sv;
        full   = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ce};
        low    = {1'b0, av[W-2:0]} + {1'b0, be[W-2:0]} + {{(W-1){1'b0}}, ce};
        e.sum   = full[W-1:0];
        e.c_out = full[W];
        e.ovf   = low[W-1] ^ full[W];
        e.zero  = (full[W-1:0] == '0);
        return e;
    endfunction

    // Output monitor: one line per transfer, scoreboard compare, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_sum", sum, held.sum);
                check("stall_c_out", c_out, held.c_out);
                check("stall_ovf", overflow, held.ovf);
                check("stall_zero", zero, held.zero);
            end
            if (out_valid && out_ready) begin
                out_fires++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    $display("out: sum=%08h c_out=%0b ovf=%0b zero=%0b", sum, c_out, overflow, zero);
                    check("sum", sum, popped.sum);
                    check("c_out", c_out, popped.c_out);
                    check("ovf", overflow, popped.ovf);
                    check("zero", zero, popped.zero);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, sub, c_in));
            end
            stall_prev = out_valid && !out_ready;
            held.sum   = sum;
            held.c_out = c_out;
            held.ovf   = overflow;
            held.zero  = zero;
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv);
        int t = 0;
        a = av; b = bv; sub = sv; c_in = cv; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        int t;
        send(av, bv, sv, cv);
        t = 1;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_latency"}, t, S);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_zero"}, zero, ez);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int start;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_zero", zero, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        directed("wrap",    32'hFFFF_FFFF, 32'h1,  1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
        directed("sub_neg", 32'h5,         32'h7,  1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'h1,  1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h1,  1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("cin",     32'h0,         32'h0,  1'b0, 1'b1, 32'h1,         1'b0, 1'b0, 1'b0);
        directed("sub_bin", 32'h7,         32'h5,  1'b1, 1'b1, 32'h1,         1'b1, 1'b0, 1'b0);
        directed("sub_eq",  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1);

        // Backpressure: fill the pipe, hold, then drain while accepting.
        out_ready = 1'b0;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        a = 32'd5; b = 32'd6; in_valid = 1'b1;
        check("full_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 check("full_in_ready_held", in_ready, 0);
        start = out_fires;
        out_ready = 1'b1;
        #1 check("drain_in_ready", in_ready, 1);
        @(posedge clk); #1;
        a = 32'd7; b = 32'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("b2b_outputs", out_fires - start, 4);

        // Reset with two beats in flight.
        a = 32'd10; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd30; b = 32'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        #1 rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1 check("midrst_no_stale", out_valid, 0);
        directed("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

        // Random handshake run against the model.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            a    = rand_operand();
            b    = rand_operand();
            sub  = $urandom_range(0, 1);
            c_in = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
